// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one LSU request at a time and answers it
// LATENCY cycles later from a byte-lane-writable word array, flagging misaligned/out-of-range access.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [3:0]  rmask_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic        drop_seen;

    logic            req;
    logic            busy;
    logic [IdxW-1:0] idx;
    logic            misaligned;
    logic            out_of_range;
    logic            bad_addr;
    logic            is_store;
    logic            err;
    logic [31:0]     load_data;

    assign req          = |(dmem_rmask | dmem_wmask);
    assign busy         = (state_q != StIdle);
    assign idx          = addr_q[IdxW+1:2];
    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = ((addr_q >> (IdxW + 2)) != 32'd0);
    assign bad_addr     = misaligned | out_of_range;
    assign is_store     = |wmask_q;
    // A request carrying both masks is performed as a store but still reported as an error.
    assign err          = bad_addr | (is_store & (|rmask_q));
    assign load_data    = bad_addr ? 32'd0 : mem_q[idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (LATENCY > 1) begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            rmask_q   <= 4'd0;
            wmask_q   <= 4'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            drop_seen <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drop_seen <= drop_seen | (busy & req);
            if (!busy && req) begin
                addr_q  <= dmem_addr;
                rmask_q <= dmem_rmask;
                wmask_q <= dmem_wmask;
                wdata_q <= dmem_wdata;
            end
            if (state_q == StResp && !is_store) begin
                rdata_q <= load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (state_q == StResp && is_store && !bad_addr) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign dmem_resp  = (state_q == StResp);
    assign dmem_err   = dmem_resp & err;
    // The array is read live during a load's RESP; otherwise the last load result is held.
    assign dmem_rdata = (dmem_resp && !is_store) ? load_data : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a vector table plus
// hand-written drop/reset sequences, and a LATENCY=1 instance for back-to-back traffic.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  rmask2, wmask2;
    logic        resp2, err2;

    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  rmask1, wmask1;
    logic        resp1, err1;

    int checks;
    int errors;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (addr2),
        .dmem_rmask (rmask2),
        .dmem_wmask (wmask2),
        .dmem_wdata (wdata2),
        .dmem_rdata (rdata2),
        .dmem_resp  (resp2),
        .dmem_err   (err2)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (addr1),
        .dmem_rmask (rmask1),
        .dmem_wmask (wmask1),
        .dmem_wdata (wdata1),
        .dmem_rdata (rdata1),
        .dmem_resp  (resp1),
        .dmem_err   (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            rmask1 = rm; wmask1 = wm; addr1 = a; wdata1 = wd;
        end else begin
            rmask2 = rm; wmask2 = wm; addr2 = a; wdata2 = wd;
        end
    endtask

    function automatic logic get_resp(input bit sel);
        return sel ? resp1 : resp2;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge one cycle after the response.
    task automatic txn(input bit sel, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd,
                       output logic after);
        drive(sel, rm, wm, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 4'h0, 4'h0, 32'h0, 32'h0);
        lat = 1;
        while (!get_resp(sel) && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        err = sel ? err1 : err2;
        rd  = sel ? rdata1 : rdata2;
        @(posedge clk);
        @(negedge clk);
        after = get_resp(sel);
    endtask

    int          lat;
    logic        e;
    logic [31:0] rd;
    logic        after;
    int          nresp;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'h0, 4'h0, 32'h0, 32'h0);

        vecs[0] = '{4'h0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{4'hF, 4'h0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{4'h0, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{4'h0, 4'h6, 32'h20, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{4'hF, 4'h0, 32'h20, 32'h0,        1'b0, 32'h11BBCC44};
        vecs[5] = '{4'hF, 4'h0, 32'h13, 32'h0,        1'b1, 32'h0};
        vecs[6] = '{4'h0, 4'hF, 32'h400, 32'h12345678, 1'b1, 32'h0};
        vecs[7] = '{4'hF, 4'h0, 32'h0,  32'h0,        1'b0, 32'h0};
        vecs[8] = '{4'hF, 4'h1, 32'h30, 32'h000000A5, 1'b1, 32'h0};
        vecs[9] = '{4'h1, 4'h0, 32'h30, 32'h0,        1'b0, 32'h000000A5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_resp", {31'd0, resp2}, 32'd0);
        check("reset_err", {31'd0, err2}, 32'd0);
        check("reset_rdata", rdata2, 32'd0);
        check("reset_drop_seen", {31'd0, dut2.drop_seen}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            txn(1'b0, vecs[i].rm, vecs[i].wm, vecs[i].addr, vecs[i].wdata, lat, e, rd, after);
            check($sformatf("vec%0d_latency", i), lat, 32'd2);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_single_pulse", i), {31'd0, after}, 32'd0);
        end
        check("no_drop_yet", {31'd0, dut2.drop_seen}, 32'd0);

        // Second load arrives while the first is in WAIT and must be dropped.
        drive(1'b0, 4'hF, 4'h0, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("drop_cycle1_resp", {31'd0, resp2}, 32'd0);
        drive(1'b0, 4'hF, 4'h0, 32'h20, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        check("drop_cycle2_resp", {31'd0, resp2}, 32'd1);
        check("drop_cycle2_rdata", rdata2, 32'hDEADBEEF);
        nresp = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            nresp += int'(resp2);
        end
        check("drop_extra_resps", nresp, 32'd0);
        check("drop_seen_set", {31'd0, dut2.drop_seen}, 32'd1);

        // Reset one edge after a store is accepted; a request during reset is also ignored.
        drive(1'b0, 4'h0, 4'hF, 32'h50, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'hF, 32'h60, 32'h00000077);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        check("rst_drop_seen_cleared", {31'd0, dut2.drop_seen}, 32'd0);
        nresp = int'(resp2);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            nresp += int'(resp2);
        end
        check("rst_midop_no_resp", nresp, 32'd0);
        txn(1'b0, 4'hF, 4'h0, 32'h50, 32'h0, lat, e, rd, after);
        check("rst_midop_load_lat", lat, 32'd2);
        check("rst_midop_load_data", rd, 32'd0);
        txn(1'b0, 4'hF, 4'h0, 32'h60, 32'h0, lat, e, rd, after);
        check("rst_req_ignored_data", rd, 32'd0);
        check("rst_cleared_old_data", rdata2, 32'd0);
        txn(1'b0, 4'hF, 4'h0, 32'h10, 32'h0, lat, e, rd, after);
        check("rst_cleared_array", rd, 32'd0);

        // LATENCY=1: requests on alternate cycles, each answered one cycle after acceptance.
        txn(1'b1, 4'h0, 4'hF, 32'h8, 32'h01020304, lat, e, rd, after);
        check("l1_store_lat", lat, 32'd1);
        check("l1_store_err", {31'd0, e}, 32'd0);
        txn(1'b1, 4'hF, 4'h0, 32'h8, 32'h0, lat, e, rd, after);
        check("l1_load_lat", lat, 32'd1);
        check("l1_load_data", rd, 32'h01020304);
        txn(1'b1, 4'h0, 4'h9, 32'h8, 32'hF0E0D0C0, lat, e, rd, after);
        check("l1_pstore_lat", lat, 32'd1);
        txn(1'b1, 4'hF, 4'h0, 32'h8, 32'h0, lat, e, rd, after);
        check("l1_pload_lat", lat, 32'd1);
        check("l1_pload_data", rd, 32'hF00203C0);
        check("l1_pulse", {31'd0, after}, 32'd0);
        check("l1_no_drops", {31'd0, dut1.drop_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256; the number of 32-bit words in the backing array, a power of two.
REQ-002 SHALL have parameter LATENCY, default 2; the number of cycles from request acceptance to dmem_resp, legal range 1..15.
REQ-003 SHALL have one clock and a synchronous active-high reset, named clk and rst as elsewhere in the core.
REQ-004 SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  clock, all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- dmem_addr  input  32  byte address from the LSU.
- dmem_rmask  input  4  load byte enables; non-zero means a load request.
- dmem_wmask  input  4  store byte enables; non-zero means a store request.
- dmem_wdata  input  32  store data, byte lane i maps to bits 8i+7:8i.
- dmem_rdata  output  32  load data, full aligned word.
- dmem_resp  output  1  one-cycle completion pulse.
- dmem_err  output  1  error flag, valid only while dmem_resp=1.

Function
REQ-005 SHALL present a request when (dmem_rmask | dmem_wmask) != 0 in a cycle; a request is a one-cycle pulse, and inputs are not held.
REQ-006 SHALL use a state machine with states IDLE, WAIT and RESP; the reset state is IDLE.
REQ-007 SHALL accept a request only in IDLE, latching addr, rmask, wmask and wdata on that edge.
REQ-008 SHALL move from IDLE to WAIT on acceptance when LATENCY>1 and load the counter with LATENCY-1; when LATENCY=1 it SHALL go directly to RESP.
REQ-009 SHALL, in WAIT, decrement the counter each cycle and move to RESP when the counter reaches 1.
REQ-010 SHALL assert dmem_resp for exactly one cycle in RESP, then return to IDLE; this puts resp exactly LATENCY cycles after the accept edge.
REQ-011 SHALL accept a request that arrives in the same cycle as RESP on the next cycle only if it is still present; a request present in WAIT or RESP SHALL be dropped and SHALL set the sticky status bit drop_seen.
REQ-012 SHALL derive word index = latched addr[2+log2(DEPTH_WORDS)-1:2].
REQ-013 SHALL, for a store (wmask!=0), update only the lanes with wmask[i]=1 at the RESP edge; all other lanes are unchanged.
REQ-014 SHALL, for a load (wmask=0, rmask!=0), drive dmem_rdata during RESP with the full word read from the array at the RESP cycle, regardless of rmask.
REQ-015 SHALL hold dmem_rdata stable after RESP until the next RESP cycle; a store's RESP SHALL leave it unchanged.
REQ-016 SHALL treat a request with both masks non-zero as a store and assert dmem_err on its response.
REQ-017 SHALL treat latched addr[1:0]!=0 as misaligned: assert dmem_err, leave the array unmodified, and drive dmem_rdata=0 for a load.
REQ-018 SHALL treat address bits above the index field being non-zero as out of range, with the same behaviour as REQ-017.
REQ-019 SHALL drive dmem_err=0 whenever dmem_resp=0.
REQ-020 SHALL make drop_seen an output-free internal register that clears on rst only.

Reset
REQ-021 SHALL, when rst=1 on a clock edge, set state IDLE, counter 0, dmem_resp 0, dmem_err 0, dmem_rdata 0, all array words 0, and drop_seen 0.
REQ-022 SHALL abandon an in-flight request on reset mid-operation (WAIT or RESP): no resp and no array write.
REQ-023 SHALL ignore any request presented in the same cycle as rst=1.

Verification
REQ-024 The bench SHALL check store then load (LATENCY=2): store addr 0x10, wmask 0xF, wdata 0xDEADBEEF -> resp 2 cycles later with err=0; then load addr 0x10, rmask 0xF -> resp 2 cycles later with rdata 0xDEADBEEF.
REQ-025 The bench SHALL check a partial store: preload 0x11223344 at 0x20, store wmask 0x6, wdata 0xAABBCCDD -> a following load returns 0x11BBCC44.
REQ-026 The bench SHALL check a drop while busy: a load at cycle 0 and a second load at cycle 1 -> exactly one resp at cycle 2, and drop_seen=1.
REQ-027 The bench SHALL check errors: load at addr 0x13 -> resp with err=1 and rdata 0; store at addr 0x400 with DEPTH_WORDS=256 -> err=1 and array unchanged; rmask=0xF with wmask=0x1 -> store performed and err=1.
REQ-028 The bench SHALL check reset mid-op: store accepted, rst asserted at the next edge -> no resp, and a following load at the same address returns 0.
REQ-029 The bench SHALL check LATENCY=1: back-to-back requests on alternate cycles -> each resp 1 cycle after its accept, with no drops.
